// File: rtl/pipeline_controller.sv
// Pipeline hazard / stall controller.
// Detects RAW hazards against the EXE and MEM stage destinations (with or
// without forwarding), sequences fixed-length data-memory stalls, arbitrates
// branch flush against freeze, and keeps a saturating stall-cycle counter.
module pipeline_controller #(
    parameter int unsigned SRAM_WAIT = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        with_src1,
    input  logic        with_src2,
    input  logic [3:0]  Reg_src1,
    input  logic [3:0]  Reg_src2,
    input  logic        EXE_WB_EN,
    input  logic        EXE_MEM_R_EN,
    input  logic [3:0]  EXE_Dest,
    input  logic        MEM_WB_EN,
    input  logic [3:0]  MEM_Dest,
    input  logic        forward_en,
    input  logic        B_taken,
    input  logic        mem_req,
    output logic        Freeze,
    output logic        Flush,
    output logic        Pipe_Stall,
    output logic [1:0]  state,
    output logic [15:0] stall_count
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        MEM_DONE = 2'b10,
        ILLEGAL  = 2'b11
    } state_e;

    // The launching RUN cycle is the first stall cycle, so MEM_WAIT covers the rest.
    localparam logic [3:0] WAIT_LOAD = 4'(SRAM_WAIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    logic        raw_exe, raw_mem, hazard;
    logic        stall_raw, legal;

    // Operand match against EXE/MEM destinations; forwarding leaves only load-use
    always_comb begin
        raw_exe = (with_src1 && (Reg_src1 == EXE_Dest)) ||
                  (with_src2 && (Reg_src2 == EXE_Dest));
        raw_mem = (with_src1 && (Reg_src1 == MEM_Dest)) ||
                  (with_src2 && (Reg_src2 == MEM_Dest));
        if (forward_en) begin
            hazard = EXE_MEM_R_EN && raw_exe;
        end else begin
            hazard = (EXE_WB_EN && raw_exe) || (MEM_WB_EN && raw_mem);
        end
    end

    // Memory-stall sequencing: RUN launches, MEM_WAIT counts down, MEM_DONE releases one cycle
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        stall_raw = 1'b0;
        legal     = 1'b1;
        case (state_q)
            RUN: begin
                if (mem_req) begin
                    stall_raw = 1'b1;
                    cnt_d     = WAIT_LOAD;
                    state_d   = (SRAM_WAIT > 1) ? MEM_WAIT : MEM_DONE;
                end
            end
            MEM_WAIT: begin
                stall_raw = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end
                if (cnt_q <= 4'd1) begin
                    state_d = MEM_DONE;
                end
            end
            MEM_DONE: begin
                state_d = RUN;
            end
            default: begin
                legal   = 1'b0;
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    // Output arbitration: stall masks branch and freeze, branch flush wins over freeze
    always_comb begin
        Pipe_Stall    = rst && stall_raw;
        Flush         = rst && legal && B_taken && !stall_raw;
        Freeze        = rst && legal && hazard && !B_taken && !stall_raw;
        stall_count_d = ((Freeze || Pipe_Stall) && (stall_count_q != '1))
                        ? stall_count_q + 16'd1 : stall_count_q;
        state         = state_q;
        stall_count   = stall_count_q;
    end

    // State, wait counter and stall statistics registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= RUN;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: tb/tb_pipeline_controller.sv
// Self-checking bench for pipeline_controller with a cycle-level reference model.
module tb_pipeline_controller;

    localparam int unsigned W = 5;

    logic        clk;
    logic        rst;
    logic        with_src1, with_src2;
    logic [3:0]  Reg_src1, Reg_src2;
    logic        EXE_WB_EN, EXE_MEM_R_EN;
    logic [3:0]  EXE_Dest;
    logic        MEM_WB_EN;
    logic [3:0]  MEM_Dest;
    logic        forward_en, B_taken, mem_req;
    logic        Freeze, Flush, Pipe_Stall;
    logic [1:0]  state;
    logic [15:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining stall cycles, pending release cycle, stall counter
    int          m_left;
    bit          m_release;
    logic [15:0] m_count;

    logic [20:0] exp_v, obs_v;

    pipeline_controller #(.SRAM_WAIT(W)) dut (
        .clk(clk), .rst(rst),
        .with_src1(with_src1), .with_src2(with_src2),
        .Reg_src1(Reg_src1), .Reg_src2(Reg_src2),
        .EXE_WB_EN(EXE_WB_EN), .EXE_MEM_R_EN(EXE_MEM_R_EN), .EXE_Dest(EXE_Dest),
        .MEM_WB_EN(MEM_WB_EN), .MEM_Dest(MEM_Dest),
        .forward_en(forward_en), .B_taken(B_taken), .mem_req(mem_req),
        .Freeze(Freeze), .Flush(Flush), .Pipe_Stall(Pipe_Stall),
        .state(state), .stall_count(stall_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic bit reads(input logic [3:0] d);
        return (with_src1 && Reg_src1 == d) || (with_src2 && Reg_src2 == d);
    endfunction

    function automatic bit ref_hazard();
        if (forward_en) return EXE_MEM_R_EN && reads(EXE_Dest);
        return (EXE_WB_EN && reads(EXE_Dest)) || (MEM_WB_EN && reads(MEM_Dest));
    endfunction

    // Expected outputs for the current cycle, then advance the model across the next edge
    task automatic model_step(output logic [20:0] e);
        bit stall, frz, fl;
        logic [1:0] st;
        if (m_release) begin
            stall = 1'b0; st = 2'b10;
        end else if (m_left > 0) begin
            stall = 1'b1; st = 2'b01;
        end else begin
            stall = mem_req; st = 2'b00;
        end
        fl  = B_taken && !stall;
        frz = ref_hazard() && !B_taken && !stall;
        e   = {frz, fl, stall, st, m_count};
        if ((frz || stall) && m_count != 16'hFFFF) m_count = m_count + 16'd1;
        if (m_release) begin
            m_release = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            if (m_left == 0) m_release = 1'b1;
        end else if (mem_req) begin
            m_left = int'(W) - 1;
            if (m_left == 0) m_release = 1'b1;
        end
    endtask

    task automatic clear_inputs();
        with_src1 = 0; with_src2 = 0; Reg_src1 = 0; Reg_src2 = 0;
        EXE_WB_EN = 0; EXE_MEM_R_EN = 0; EXE_Dest = 0;
        MEM_WB_EN = 0; MEM_Dest = 0; forward_en = 0; B_taken = 0; mem_req = 0;
    endtask

    // Assert reset between edges, check the asynchronous clear, release with quiet inputs
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
        checks++;
        if (obs_v !== 21'd0) begin
            errors++;
            $display("FAIL %s async: got %h required %h", tag, obs_v, 21'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
        checks++;
        if (obs_v !== 21'd0) begin
            errors++;
            $display("FAIL %s held: got %h required %h", tag, obs_v, 21'd0);
        end
        clear_inputs();
        rst = 1'b1;
        m_left = 0; m_release = 1'b0; m_count = '0;
    endtask

    task automatic test_reset();
        // Inputs that would otherwise raise every output
        mem_req = 1; B_taken = 1; with_src1 = 1; Reg_src1 = 3; EXE_WB_EN = 1; EXE_Dest = 3;
        do_reset("reset");
    endtask

    task automatic test_hazard_no_fwd();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            EXE_WB_EN = 1; EXE_Dest = 3; with_src1 = 1; Reg_src1 = 3;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v || Freeze !== 1'b1 || stall_count !== 16'(i)) begin
                errors++;
                $display("FAIL hazard_no_fwd cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
        // MEM-stage match without forwarding, including register 0
        @(negedge clk);
        clear_inputs();
        MEM_WB_EN = 1; MEM_Dest = 0; with_src2 = 1; Reg_src2 = 0;
        #1;
        model_step(exp_v);
        obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
        checks++;
        if (obs_v !== exp_v || Freeze !== 1'b1) begin
            errors++;
            $display("FAIL hazard_mem_r0: got %h required %h", obs_v, exp_v);
        end
    endtask

    task automatic test_load_use();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_inputs();
            forward_en = 1; EXE_WB_EN = 1; EXE_Dest = 3; with_src1 = 1; Reg_src1 = 3;
            EXE_MEM_R_EN = (i >= 2);
            MEM_WB_EN = 1; MEM_Dest = 3;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v || Freeze !== (i >= 2)) begin
                errors++;
                $display("FAIL load_use cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_mem_stall();
        logic [1:0] seq [0:7];
        seq = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b00, 2'b01};
        do_reset("mem_stall_rst");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_req = 1;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v || state !== seq[i] || Pipe_Stall !== (i != 5)) begin
                errors++;
                $display("FAIL mem_stall cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
        // Let the second access finish so later tests start idle
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_req = 0;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL mem_stall_drain cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_branch_during_stall();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            clear_inputs();
            mem_req = (i == 0);
            B_taken = (i >= 2);
            EXE_WB_EN = 1; EXE_Dest = 7; with_src2 = 1; Reg_src2 = 7;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v ||
                (i >= 2 && i < 5 && (Flush !== 1'b0 || Freeze !== 1'b0)) ||
                (i == 5 && (Flush !== 1'b1 || Freeze !== 1'b0))) begin
                errors++;
                $display("FAIL branch_stall cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_inputs();
            mem_req = 1;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL mid_stall_pre cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
        do_reset("mid_stall_rst");
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            mem_req = 1;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v || (i < 5 && Pipe_Stall !== 1'b1)) begin
                errors++;
                $display("FAIL mid_stall_post cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
        do_reset("mid_stall_clr");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            with_src1    = 1'($urandom);
            with_src2    = 1'($urandom);
            Reg_src1     = 4'($urandom_range(0, 3));
            Reg_src2     = 4'($urandom_range(0, 3));
            EXE_WB_EN    = 1'($urandom);
            EXE_MEM_R_EN = 1'($urandom);
            EXE_Dest     = 4'($urandom_range(0, 3));
            MEM_WB_EN    = 1'($urandom);
            MEM_Dest     = 4'($urandom_range(0, 3));
            forward_en   = 1'($urandom);
            B_taken      = ($urandom_range(0, 3) == 0);
            mem_req      = ($urandom_range(0, 7) == 0);
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset("sat_rst");
        @(negedge clk);
        EXE_WB_EN = 1; EXE_Dest = 9; with_src1 = 1; Reg_src1 = 9;
        // 65534 freeze edges bring the counter to 16'hFFFE
        for (int i = 0; i < 65534; i++) begin
            model_step(exp_v);
            @(negedge clk);
        end
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            mem_req = 1;
            #1;
            model_step(exp_v);
            obs_v = {Freeze, Flush, Pipe_Stall, state, stall_count};
            checks++;
            if (obs_v !== exp_v || stall_count !== ((i == 0) ? 16'hFFFE : 16'hFFFF)) begin
                errors++;
                $display("FAIL saturate cyc %0d: got %h required %h", i, obs_v, exp_v);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        rst = 1'b0;
        clear_inputs();
        m_left = 0; m_release = 1'b0; m_count = '0;
        #12;
        rst = 1'b1;
        test_reset();
        test_hazard_no_fwd();
        test_load_use();
        test_mem_stall();
        test_branch_during_stall();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
